// File: rtl/seg_scan_pkg.sv
// seg_scan_pkg: shared constants, types and helpers for the seven-segment scan capture.
//   SEG_0..SEG_9, SEG_BLANK : segment patterns {a,b,c,d,e,f,g}, active-high
//   DIGIT_BLANK             : BCD code for a blank or not-yet-captured digit
//   HOUR10..SEC0            : digit index of each position, matching the enable bit number
package seg_scan_pkg;
  localparam logic [6:0] SEG_0     = 7'h7E;
  localparam logic [6:0] SEG_1     = 7'h30;
  localparam logic [6:0] SEG_2     = 7'h6D;
  localparam logic [6:0] SEG_3     = 7'h79;
  localparam logic [6:0] SEG_4     = 7'h33;
  localparam logic [6:0] SEG_5     = 7'h5B;
  localparam logic [6:0] SEG_6     = 7'h5F;
  localparam logic [6:0] SEG_7     = 7'h70;
  localparam logic [6:0] SEG_8     = 7'h7F;
  localparam logic [6:0] SEG_9     = 7'h73;
  localparam logic [6:0] SEG_BLANK = 7'h00;
  localparam logic [3:0] DIGIT_BLANK = 4'hF;
  localparam int HOUR10 = 5;
  localparam int HOUR0  = 4;
  localparam int MIN10  = 3;
  localparam int MIN0   = 2;
  localparam int SEC10  = 1;
  localparam int SEC0   = 0;
  typedef enum logic [1:0] {ENB_IDLE, ENB_LEGAL, ENB_ILLEGAL} enb_class_e;
  // All high is idle, exactly one low bit selects a digit, anything else is illegal.
  function automatic enb_class_e classify_enb(input logic [5:0] enb);
    int zeros;
    zeros = 0;
    for (int i = 0; i < 6; i++)
      if (!enb[i]) zeros++;
    return zeros == 0 ? ENB_IDLE : zeros == 1 ? ENB_LEGAL : ENB_ILLEGAL;
  endfunction
  // Position of the low bit; only meaningful for a legal enable.
  function automatic logic [2:0] low_index(input logic [5:0] enb);
    logic [2:0] r;
    r = '0;
    for (int i = 0; i < 6; i++)
      if (!enb[i]) r = 3'(i);
    return r;
  endfunction
endpackage

// File: rtl/seg_scan_capture_seg7_to_bcd.sv
// seg7_to_bcd: combinational decode of a seven-segment pattern back to a BCD digit.
//   seg     in  7  segments {a,b,c,d,e,f,g}, active-high
//   code    out 4  decoded digit, DIGIT_BLANK for an all-off pattern
//   invalid out 1  pattern is neither a digit nor blank
module seg7_to_bcd
  import seg_scan_pkg::*;
(
  input  logic [6:0] seg,
  output logic [3:0] code,
  output logic       invalid
);
  always_comb begin
    code = DIGIT_BLANK;
    invalid = 1'b0;
    case (seg)
      SEG_0:     code = 4'd0;
      SEG_1:     code = 4'd1;
      SEG_2:     code = 4'd2;
      SEG_3:     code = 4'd3;
      SEG_4:     code = 4'd4;
      SEG_5:     code = 4'd5;
      SEG_6:     code = 4'd6;
      SEG_7:     code = 4'd7;
      SEG_8:     code = 4'd8;
      SEG_9:     code = 4'd9;
      SEG_BLANK: code = DIGIT_BLANK;
      default:   invalid = 1'b1;
    endcase
  end
endmodule

// File: rtl/seg_scan_capture.sv
// seg_scan_capture: rebuilds HH:MM:SS from a multiplexed seven-segment display bus.
//   gen_clk     in  1  scan clock shared with the display multiplexer
//   rst_n       in  1  asynchronous active-low reset
//   i_seg_enb   in  6  active-low digit enables (5 = hour-left .. 0 = sec-right)
//   i_seg       in  7  segments {a,b,c,d,e,f,g}, active-high
//   o_hour10..o_sec0 out 4 committed BCD digits, 4'hF when blank or not captured
//   o_valid     out 1  every digit committed since the last reset or timeout
//   o_update    out 1  pulse when a commit changes a digit's value
//   o_err       out 1  pulse on an illegal enable or undecodable segment pattern
module seg_scan_capture
  import seg_scan_pkg::*;
#(
  parameter int STABLE_SCANS = 2,
  parameter int SCAN_TIMEOUT = 64
) (
  input  logic       gen_clk,
  input  logic       rst_n,
  input  logic [5:0] i_seg_enb,
  input  logic [6:0] i_seg,
  output logic [3:0] o_hour10,
  output logic [3:0] o_hour0,
  output logic [3:0] o_min10,
  output logic [3:0] o_min0,
  output logic [3:0] o_sec10,
  output logic [3:0] o_sec0,
  output logic       o_valid,
  output logic       o_update,
  output logic       o_err
);
  localparam logic [2:0]  STABLE   = 3'(STABLE_SCANS);
  localparam logic [15:0] TMO      = 16'(SCAN_TIMEOUT);
  localparam logic [15:0] TMO_LAST = 16'(SCAN_TIMEOUT - 1);
  logic [5:0]  enb_q, prev_enb, seen;
  logic [6:0]  seg_q;
  logic [3:0]  code, cur_cand, cur_dig;
  logic [2:0]  idx, cur_cnt, cnt_new;
  logic [15:0] tcnt;
  logic        bad_seg, scan, take, commit, timeout;
  enb_class_e  cls;
  logic [3:0]  cand  [6];
  logic [2:0]  cnt   [6];
  logic [3:0]  digit [6];
  seg7_to_bcd u_dec (
    .seg    (seg_q),
    .code   (code),
    .invalid(bad_seg)
  );
  // A scan is a change to a new legal enable; holding one enable counts once.
  always_comb begin
    cls = classify_enb(enb_q);
    idx = low_index(enb_q);
    cur_cand = DIGIT_BLANK;
    cur_cnt = '0;
    cur_dig = DIGIT_BLANK;
    for (int i = 0; i < 6; i++)
      if (idx == 3'(i)) begin
        cur_cand = cand[i];
        cur_cnt = cnt[i];
        cur_dig = digit[i];
      end
    scan = cls == ENB_LEGAL && enb_q != prev_enb;
    take = scan && !bad_seg;
    cnt_new = code != cur_cand ? 3'd1 : cur_cnt == STABLE ? STABLE : cur_cnt + 3'd1;
    commit = take && cnt_new == STABLE;
    timeout = cls != ENB_LEGAL && tcnt == TMO_LAST;
  end
  always_ff @(posedge gen_clk or negedge rst_n)
    if (!rst_n) begin
      enb_q <= '1;
      prev_enb <= '1;
      seg_q <= '0;
      seen <= '0;
      tcnt <= '0;
      o_update <= 1'b0;
      o_err <= 1'b0;
      for (int i = 0; i < 6; i++) begin
        cand[i] <= DIGIT_BLANK;
        cnt[i] <= '0;
        digit[i] <= DIGIT_BLANK;
      end
    end else begin
      enb_q <= i_seg_enb;
      prev_enb <= enb_q;
      seg_q <= i_seg;
      tcnt <= cls == ENB_LEGAL ? '0 : tcnt == TMO ? tcnt : tcnt + 16'd1;
      o_update <= commit && code != cur_dig;
      o_err <= cls == ENB_ILLEGAL || (scan && bad_seg);
      seen <= timeout ? '0 : commit ? seen | (6'b1 << idx) : seen;
      for (int i = 0; i < 6; i++) begin
        if (timeout)
          cnt[i] <= '0;
        else if (take && idx == 3'(i)) begin
          cand[i] <= code;
          cnt[i] <= cnt_new;
        end
        if (commit && idx == 3'(i))
          digit[i] <= code;
      end
    end
  assign o_valid  = &seen;
  assign o_hour10 = digit[HOUR10];
  assign o_hour0  = digit[HOUR0];
  assign o_min10  = digit[MIN10];
  assign o_min0   = digit[MIN0];
  assign o_sec10  = digit[SEC10];
  assign o_sec0   = digit[SEC0];
endmodule
